// File: rtl/prod_accumulator_if.sv
// Valid/ready bundle between the signed multiplier, the product accumulator
// and the downstream consumer of per-frame sums.
interface prod_accumulator_if #(
  parameter int CNT_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [63:0]       in_product;
  logic              in_sign;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [63:0]       out_acc;
  logic [CNT_W-1:0]  out_count;
  logic              out_sat;
  logic              out_sign_err;

  modport slave (
    input  in_valid, in_product, in_sign, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_sat, out_sign_err
  );

  modport master (
    output in_valid, in_product, in_sign, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_sat, out_sign_err
  );
endinterface

// File: rtl/prod_accumulator.sv
// Saturating accumulator of signed 64-bit products, one result per frame of
// up to N_TERMS beats, with a product-vs-sign consistency check.
module prod_accumulator #(
  parameter int N_TERMS = 8,
  parameter int CNT_W   = $clog2(N_TERMS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  prod_accumulator_if.slave    bus
);

  typedef enum logic {ACC, DONE} state_t;

  state_t            state_reg;
  logic              in_ready_reg;
  logic              out_valid_reg;
  logic [63:0]       acc_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              sat_reg;
  logic              sign_err_reg;

  logic [64:0]       sum_wide;
  logic [63:0]       sum_next;
  logic              ovf_next;
  logic [CNT_W-1:0]  count_next;
  logic              sign_bad;
  logic              accept;
  logic              frame_end;

  // Overflow is visible as disagreement between the two top bits of the
  // sign-extended 65-bit sum; bit 64 gives the true sign for the clamp.
  always_comb begin
    sum_wide   = {acc_reg[63], acc_reg} + {bus.in_product[63], bus.in_product};
    ovf_next   = sum_wide[64] ^ sum_wide[63];
    sum_next   = sum_wide[63:0];
    if (ovf_next) begin
      sum_next = sum_wide[64] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
    end
    count_next = count_reg + CNT_W'(1);
    sign_bad   = (bus.in_product != 64'd0) && (bus.in_product[63] != bus.in_sign);
    accept     = bus.in_valid && in_ready_reg;
    frame_end  = bus.in_last || (count_next == CNT_W'(N_TERMS));
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state_reg     <= ACC;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      acc_reg       <= 64'd0;
      count_reg     <= '0;
      sat_reg       <= 1'b0;
      sign_err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ACC: begin
          if (accept) begin
            acc_reg      <= sum_next;
            count_reg    <= count_next;
            sat_reg      <= sat_reg | ovf_next;
            sign_err_reg <= sign_err_reg | sign_bad;
            if (frame_end) begin
              state_reg     <= DONE;
              in_ready_reg  <= 1'b0;
              out_valid_reg <= 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_reg     <= ACC;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            acc_reg       <= 64'd0;
            count_reg     <= '0;
            sat_reg       <= 1'b0;
            sign_err_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg     <= ACC;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_reg;
  assign bus.out_valid    = out_valid_reg;
  assign bus.out_acc      = acc_reg;
  assign bus.out_count    = count_reg;
  assign bus.out_sat      = sat_reg;
  assign bus.out_sign_err = sign_err_reg;

endmodule

// File: tb/tb_prod_accumulator.sv
// Directed bench for prod_accumulator: frames, saturation, sign check,
// backpressure, clr and reset, all against hand-computed values.
module tb_prod_accumulator;

  localparam int N_TERMS = 8;
  localparam int CNT_W   = $clog2(N_TERMS + 1);

  logic clk;
  logic rst_n;
  logic clr;

  prod_accumulator_if #(.CNT_W(CNT_W)) bus ();

  prod_accumulator #(.N_TERMS(N_TERMS), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [63:0] p, input logic s, input logic l);
    bus.in_valid   = 1'b1;
    bus.in_product = p;
    bus.in_sign    = s;
    bus.in_last    = l;
    tick();
    bus.in_valid   = 1'b0;
    bus.in_last    = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".in_ready"},  64'(bus.in_ready), 64'd1);
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, ".out_acc"},   bus.out_acc, 64'd0);
    chk({tag, ".out_count"}, 64'(bus.out_count), 64'd0);
    chk({tag, ".out_sat"},   64'(bus.out_sat), 64'd0);
    chk({tag, ".out_err"},   64'(bus.out_sign_err), 64'd0);
  endtask

  task automatic check_result(input string tag, input logic [63:0] acc,
                              input int cnt, input logic sat, input logic err);
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, ".in_ready"},  64'(bus.in_ready), 64'd0);
    chk({tag, ".out_acc"},   bus.out_acc, acc);
    chk({tag, ".out_count"}, 64'(bus.out_count), 64'(cnt));
    chk({tag, ".out_sat"},   64'(bus.out_sat), 64'(sat));
    chk({tag, ".out_err"},   64'(bus.out_sign_err), 64'(err));
  endtask

  task automatic take(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, ".post_hs_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, ".post_hs_ready"}, 64'(bus.in_ready), 64'd1);
    chk({tag, ".post_hs_acc"},   bus.out_acc, 64'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    clr            = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_product = 64'd0;
    bus.in_sign    = 1'b0;
    bus.in_last    = 1'b0;
    bus.out_ready  = 1'b0;
    tick();
    tick();
    check_idle("reset");
    rst_n = 1'b1;
    tick();

    // Basic frame: 1..8, no in_last, ends on count limit
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("basic.ready_b%0d", i), 64'(bus.in_ready), 64'd1);
      beat(64'(i), 1'b0, 1'b0);
    end
    check_result("basic", 64'd36, 8, 1'b0, 1'b0);
    tick();
    chk("basic.ready_held", 64'(bus.in_ready), 64'd0);
    take("basic");

    // Early end with signs
    beat(-64'sd5, 1'b1, 1'b0);
    beat(64'd3,   1'b0, 1'b0);
    beat(64'd0,   1'b1, 1'b1);
    check_result("early", 64'hFFFF_FFFF_FFFF_FFFE, 3, 1'b0, 1'b0);
    take("early");

    // Positive saturation, then continue from the clamp
    beat(64'h7FFF_FFFF_FFFF_FFF0, 1'b0, 1'b0);
    beat(64'h100, 1'b0, 1'b0);
    beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    check_result("sat_pos", 64'h7FFF_FFFF_FFFF_FFFE, 3, 1'b1, 1'b0);
    take("sat_pos");

    // Negative saturation
    beat(64'h8000_0000_0000_0010, 1'b1, 1'b0);
    beat(64'hFFFF_FFFF_FFFF_FF00, 1'b1, 1'b1);
    check_result("sat_neg", 64'h8000_0000_0000_0000, 2, 1'b1, 1'b0);
    take("sat_neg");

    // Sign mismatch, then a clean single-beat frame
    beat(64'd7, 1'b1, 1'b1);
    check_result("sign_err", 64'd7, 1, 1'b0, 1'b1);
    take("sign_err");
    beat(64'd4, 1'b0, 1'b1);
    check_result("sign_ok", 64'd4, 1, 1'b0, 1'b0);
    take("sign_ok");

    // Backpressure with in_valid held high
    beat(64'd10, 1'b0, 1'b0);
    beat(64'd20, 1'b0, 1'b1);
    bus.in_valid   = 1'b1;
    bus.in_product = 64'd999;
    for (int i = 0; i < 5; i++) begin
      check_result($sformatf("bp%0d", i), 64'd30, 2, 1'b0, 1'b0);
      tick();
    end
    bus.in_valid = 1'b0;
    take("bp");
    beat(64'd5, 1'b0, 1'b1);
    check_result("bp_next", 64'd5, 1, 1'b0, 1'b0);
    take("bp_next");

    // in_last on the N_TERMS-th beat ends exactly one frame
    for (int i = 1; i <= 8; i++) beat(64'd1, 1'b0, (i == 8));
    check_result("last8", 64'd8, 8, 1'b0, 1'b0);
    take("last8");

    // clr mid-frame with a beat presented: beat dropped, partial sum gone
    beat(64'd1, 1'b0, 1'b0);
    beat(64'd2, 1'b0, 1'b0);
    beat(64'd3, 1'b0, 1'b0);
    clr            = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_product = 64'd100;
    tick();
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    check_idle("clr_mid");
    for (int i = 1; i <= 4; i++) beat(64'd1, 1'b0, (i == 4));
    check_result("clr_next", 64'd4, 4, 1'b0, 1'b0);
    take("clr_next");

    // clr in DONE discards the pending result
    beat(64'd9, 1'b0, 1'b1);
    check_result("clr_done_pre", 64'd9, 1, 1'b0, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_idle("clr_done");

    // Reset mid-frame
    beat(64'd5, 1'b1, 1'b0);
    beat(64'd5, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    check_idle("rst_mid");
    rst_n = 1'b1;
    beat(64'd3, 1'b0, 1'b1);
    check_result("rst_next", 64'd3, 1, 1'b0, 1'b0);
    take("rst_next");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prod_accumulator.md
# prod_accumulator

Downstream stage of the 32x32 signed shift-and-add multiplier. Consumes its 64-bit two's-complement product and sign flag through a valid/ready handshake. Accumulates up to N_TERMS products into a saturating accumulator and presents one result per frame (dot-product style) through a second valid/ready handshake. Also checks each product against the multiplier's sign output.

## Interface
- N_TERMS, 8, maximum products per frame (≥2); frame also ends early on in_last
- CNT_W, $clog2(N_TERMS+1), width of term counter
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- clr  in  1  synchronous frame abort; discards partial sum
- in_valid  in  1  product beat valid
- in_ready  out  1  block can accept a beat
- in_product  in  64  signed product from multiplier
- in_sign  in  1  multiplier sign output for this product
- in_last  in  1  beat is last of frame
- out_valid  out  1  frame result valid
- out_ready  in  1  downstream accepts result
- out_acc  out  64  signed saturated frame sum
- out_count  out  CNT_W  number of products in frame
- out_sat  out  1  saturation occurred at least once in frame
- out_sign_err  out  1  at least one beat had a sign mismatch in frame

## Operation
- FSM states: ACC, DONE. Reset state ACC.
- In ACC:
  - in_ready=1, out_valid=0.
  - A beat is accepted when in_valid && in_ready.
  - On accept: acc ← sat(acc + in_product), count ← count+1.
  - Sign mismatch sets sign_err: in_product≠0 && in_product[63]≠in_sign. A zero product with in_sign=1 is legal.
- Frame end is the accepted beat with in_last=1 or count+1==N_TERMS. Next state DONE.
- In DONE:
  - in_ready=0, out_valid=1.
  - out_acc, out_count, out_sat and out_sign_err are stable until handshake.
  - On out_valid && out_ready: acc, count, sat and sign_err ← 0; state → ACC.
- Saturating add:
  - Sum is formed in 65 bits.
  - If the result is >2^63−1, it clamps to 64'h7FFF_FFFF_FFFF_FFFF; if <−2^63, it clamps to 64'h8000_0000_0000_0000. Either clamp sets sat.
  - Later beats continue from the clamped value.
- clr (ACC or DONE): acc, count and flags ← 0; state → ACC. Any beat presented in the same cycle is dropped. A result pending in DONE is discarded.
- Priority: rst_n low > clr > handshake/accumulate.
- out_* fields are driven from internal registers in both states. They are meaningful only while out_valid=1.

## Timing
- Reset values:
  - in_ready=1, out_valid=0
  - out_acc=0, out_count=0, out_sat=0, out_sign_err=0
  - state ACC
- Throughput: one product per cycle in ACC, with no bubbles between beats.
- Latency: out_valid rises the cycle after the frame-ending beat is accepted.
- out_acc includes that final beat.
- Minimum gap between frames is one cycle (the DONE/handshake cycle). in_ready returns to 1 the cycle after out handshake.
- in_ready is a registered function of state only. It has no combinational path from out_ready.
- Downstream stall: DONE holds indefinitely while out_ready=0, and all outputs are stable.
- Single-beat frame (in_last on first beat): out_count=1, out_acc=in_product.
- in_last on the N_TERMS-th beat gives the same single frame end, not two.
- rst_n low mid-frame or in DONE: all state returns to reset values at the next edge.

## Test plan
- Basic frame, N_TERMS=8, no in_last: products 1..8 back-to-back.
  - Required: out_valid one cycle after beat 8, out_acc=36, out_count=8, out_sat=0, out_sign_err=0.
  - in_ready=0 until out_ready.
- Early end with signs: beats −5 (sign 1), 3 (sign 0), 0 (sign 1, in_last).
  - Required: out_acc=−2 (64'hFFFF_FFFF_FFFF_FFFE), out_count=3, out_sign_err=0.
- Saturation, positive then negative, in one frame: beats 64'h7FFF_FFFF_FFFF_FFF0, 64'h100, then −1 with in_last.
  - Required: out_acc=64'h7FFF_FFFF_FFFF_FFFE, out_sat=1.
  - Mirror case: 64'h8000_0000_0000_0010 plus −64'h100 must clamp to 64'h8000_0000_0000_0000 with out_sat=1.
- Sign check: beat 7 with in_sign=1, in_last.
  - Required: out_sign_err=1, out_acc=7.
  - The following frame must report out_sign_err=0.
- Backpressure: hold out_ready=0 for 5 cycles after the frame ends, with in_valid=1 throughout.
  - Required: no beat accepted, out_* stable.
  - After the handshake, in_ready=1 the next cycle and the next frame starts from acc=0.
- clr and reset:
  - clr after 3 beats of 10: out_count of the next frame counts only new beats.
  - clr asserted with in_valid=1: that beat is dropped.
  - clr in DONE: result discarded, out_valid=0 next cycle.
  - rst_n=0 mid-frame: all outputs take reset values at the next edge.
